// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave). One request may be outstanding at a time.
interface imem_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_valid;
  logic [31:0]      imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, issues single-outstanding fetches to a variable-latency
// instruction memory and drives the IF/ID register, with a 1-entry skid and EX redirect.
module instruction_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  imem_if.master           imem,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic [31:0]      instruction,
  output logic [WIDTH-1:0] pc_out,
  output logic             inst_valid
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {REQ, WAIT, SKID} state_t;

  function automatic logic [WIDTH-1:0] pc_inc(input logic [WIDTH-1:0] pc);
    return pc + WIDTH'(4);
  endfunction

  function automatic logic [WIDTH-1:0] align4(input logic [WIDTH-1:0] addr);
    return {addr[WIDTH-1:2], 2'b00};
  endfunction

  state_t           state_q, state_d;
  logic             kill_q, kill_d;
  logic [WIDTH-1:0] pc_p0, pc_p0_d;
  logic [31:0]      skid_instr_p1;
  logic [WIDTH-1:0] skid_pc_p1;
  logic [31:0]      instr_p1;
  logic [WIDTH-1:0] pc_p1;
  logic             vld_p1, vld_p1_d;
  logic             load_mem, load_skid, fill_skid;
  logic             req;

  assign req            = (state_q == REQ) & ~stall & ~branch_taken & ~rst;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_p0;

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    pc_p0_d   = pc_p0;
    load_mem  = 1'b0;
    load_skid = 1'b0;
    fill_skid = 1'b0;
    vld_p1_d  = stall ? vld_p1 : 1'b0;

    if (branch_taken) begin
      pc_p0_d  = align4(branch_target);
      vld_p1_d = 1'b0;
      // A request still in flight must be swallowed when it eventually returns.
      if (state_q == WAIT && !imem.imem_valid) begin
        kill_d  = 1'b1;
        state_d = WAIT;
      end else begin
        kill_d  = 1'b0;
        state_d = REQ;
      end
    end else begin
      unique case (state_q)
        REQ: begin
          if (req) state_d = WAIT;
        end
        WAIT: begin
          if (imem.imem_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = REQ;
            end else if (!stall) begin
              load_mem = 1'b1;
              vld_p1_d = 1'b1;
              pc_p0_d  = pc_inc(pc_p0);
              state_d  = REQ;
            end else begin
              fill_skid = 1'b1;
              pc_p0_d   = pc_inc(pc_p0);
              state_d   = SKID;
            end
          end
        end
        SKID: begin
          if (!stall) begin
            load_skid = 1'b1;
            vld_p1_d  = 1'b1;
            state_d   = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  // p0: fetch control and PC; p1: IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      kill_q   <= 1'b0;
      pc_p0    <= RESET_PC;
      vld_p1   <= 1'b0;
      instr_p1 <= NOP;
      pc_p1    <= RESET_PC;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pc_p0   <= pc_p0_d;
      vld_p1  <= vld_p1_d;
      if (load_mem) begin
        instr_p1 <= imem.imem_rdata;
        pc_p1    <= pc_p0;
      end else if (load_skid) begin
        instr_p1 <= skid_instr_p1;
        pc_p1    <= skid_pc_p1;
      end
    end
  end

  // Skid contents are only meaningful in SKID, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill_skid) begin
      skid_instr_p1 <= imem.imem_rdata;
      skid_pc_p1    <= pc_p0;
    end
  end

  assign instruction = instr_p1;
  assign pc_out      = pc_p1;
  assign inst_valid  = vld_p1;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural memory with random latency, random
// stall/redirect traffic, and an in-order PC-stream reference model.
`timescale 1ns/1ps
module tb_instruction_fetch;
  localparam int          WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        inst_valid;

  imem_if #(.WIDTH(WIDTH)) bus ();

  instruction_fetch #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (bus),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .inst_valid   (inst_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  // ---------------- behavioural instruction memory ----------------
  int          lat_mode = 0;
  int          lat_fixed = 1;
  int          proto_viol = 0;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic        m_req_s, m_rst_s;
  logic [31:0] m_addr_s;

  function automatic int pick_lat();
    int r;
    case (lat_mode)
      1: begin r = $urandom_range(0, 2); return 1 + 2 * r; end
      2: return $urandom_range(1, 4);
      default: return lat_fixed;
    endcase
  endfunction

  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    mem_busy = 1'b0;
    mem_cnt  = 0;
    mem_addr = 32'h0;
    forever begin
      @(negedge clk);
      m_req_s  = bus.imem_req;
      m_addr_s = bus.imem_addr;
      m_rst_s  = rst;
      @(posedge clk);
      #1;
      bus.imem_valid = 1'b0;
      if (m_rst_s) begin
        mem_busy = 1'b0;
      end else begin
        if (m_req_s) begin
          if (mem_busy) proto_viol++;
          mem_busy = 1'b1;
          mem_addr = m_addr_s;
          mem_cnt  = pick_lat();
        end
        if (mem_busy) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = mem_word(mem_addr);
            mem_busy = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- reference model / monitor ----------------
  // Decode accepts whenever inst_valid & ~stall outside a redirect; accepted
  // PCs must form RESET_PC, +4, ... restarting at (target & ~3) after a redirect.
  logic [31:0] acc_pc_q[$];
  logic [31:0] acc_ins_q[$];
  logic [31:0] exp_pc_q[$];
  int          acc_cyc_q[$];
  logic [31:0] exp_next;
  int          cyc;
  int          hold_viol = 0;
  int          req_viol = 0;
  logic        p_hold;
  logic [31:0] p_ins, p_pc;

  initial begin
    exp_next = RESET_PC;
    cyc      = 0;
    p_hold   = 1'b0;
    p_ins    = 32'h0;
    p_pc     = 32'h0;
    forever begin
      @(negedge clk);
      if (p_hold && (inst_valid !== 1'b1 || instruction !== p_ins || pc_out !== p_pc)) hold_viol++;
      if (bus.imem_req === 1'b1 && (stall === 1'b1 || branch_taken === 1'b1 || rst === 1'b1)) req_viol++;
      if (rst) begin
        exp_next = RESET_PC;
        cyc      = 0;
      end else begin
        if (inst_valid === 1'b1 && !stall && !branch_taken) begin
          acc_pc_q.push_back(pc_out);
          acc_ins_q.push_back(instruction);
          acc_cyc_q.push_back(cyc);
          exp_pc_q.push_back(exp_next);
          exp_next = exp_next + 32'd4;
        end
        if (branch_taken) exp_next = branch_target & ~32'h3;
        cyc++;
      end
      p_hold = !rst && !branch_taken && inst_valid && stall;
      p_ins  = instruction;
      p_pc   = pc_out;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    acc_pc_q.delete();
    acc_ins_q.delete();
    acc_cyc_q.delete();
    exp_pc_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    clear_log();
    hold_viol = 0;
    req_viol = 0;
    proto_viol = 0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    lat_mode = 0;
    lat_fixed = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid); end
      checks++; if (pc_out !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h want %h", pc_out, RESET_PC); end
      checks++; if (instruction !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instruction, NOP); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
    end
    tick();
    rst = 1'b0;
    clear_log();
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL first_addr got %h want %h", bus.imem_addr, RESET_PC); end
  endtask

  task automatic test_sequential();
    lat_mode = 0;
    lat_fixed = 1;
    apply_reset();
    repeat (20) tick();
    checks++; if (acc_pc_q.size() != 9) begin errors++; $display("FAIL seq_count got %0d want 9", acc_pc_q.size()); end
    for (int i = 0; i < acc_pc_q.size() && i < 9; i++) begin
      checks++; if (acc_cyc_q[i] != 2 + 2 * i) begin errors++; $display("FAIL seq_cycle[%0d] got %0d want %0d", i, acc_cyc_q[i], 2 + 2 * i); end
      checks++; if (acc_pc_q[i] !== RESET_PC + 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, acc_pc_q[i], RESET_PC + 32'(4 * i)); end
      checks++; if (acc_ins_q[i] !== mem_word(acc_pc_q[i])) begin errors++; $display("FAIL seq_instr[%0d] got %h want %h", i, acc_ins_q[i], mem_word(acc_pc_q[i])); end
    end
  endtask

  task automatic test_variable_latency();
    lat_mode = 1;
    apply_reset();
    repeat (80) tick();
    checks++; if (acc_pc_q.size() < 10) begin errors++; $display("FAIL varlat_count got %0d want >=10", acc_pc_q.size()); end
    for (int i = 0; i < acc_pc_q.size(); i++) begin
      checks++; if (acc_pc_q[i] !== exp_pc_q[i]) begin errors++; $display("FAIL varlat_pc[%0d] got %h want %h", i, acc_pc_q[i], exp_pc_q[i]); end
      checks++; if (acc_ins_q[i] !== mem_word(acc_pc_q[i])) begin errors++; $display("FAIL varlat_instr[%0d] got %h want %h", i, acc_ins_q[i], mem_word(acc_pc_q[i])); end
    end
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL varlat_req_in_wait got %0d want 0", proto_viol); end
    checks++; if (req_viol != 0) begin errors++; $display("FAIL varlat_req_gating got %0d want 0", req_viol); end
  endtask

  task automatic test_stall_skid();
    bit ok;
    logic [31:0] fetch_pc, snap_pc, snap_ins;
    lat_mode = 0;
    lat_fixed = 3;
    apply_reset();
    wait_req(ok);
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL skid_req_timeout got 0 want 1"); end
    fetch_pc = bus.imem_addr;
    tick();
    stall = 1'b1;
    @(negedge clk);
    snap_pc = pc_out;
    snap_ins = instruction;
    repeat (8) tick();
    @(negedge clk);
    checks++; if (pc_out !== snap_pc) begin errors++; $display("FAIL skid_hold_pc got %h want %h", pc_out, snap_pc); end
    checks++; if (instruction !== snap_ins) begin errors++; $display("FAIL skid_hold_instr got %h want %h", instruction, snap_ins); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL skid_hold_valid got %b want 0", inst_valid); end
    tick();
    stall = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL skid_out_valid got %b want 1", inst_valid); end
    checks++; if (pc_out !== fetch_pc) begin errors++; $display("FAIL skid_out_pc got %h want %h", pc_out, fetch_pc); end
    checks++; if (instruction !== mem_word(fetch_pc)) begin errors++; $display("FAIL skid_out_instr got %h want %h", instruction, mem_word(fetch_pc)); end
    repeat (12) tick();
    for (int i = 0; i < acc_pc_q.size(); i++) begin
      checks++; if (acc_pc_q[i] !== exp_pc_q[i]) begin errors++; $display("FAIL skid_seq_pc[%0d] got %h want %h", i, acc_pc_q[i], exp_pc_q[i]); end
    end
    checks++; if (req_viol != 0) begin errors++; $display("FAIL skid_req_during_stall got %0d want 0", req_viol); end
  endtask

  task automatic test_branch_flush();
    bit ok;
    // Redirect while the response is still outstanding.
    lat_mode = 0;
    lat_fixed = 3;
    apply_reset();
    wait_req(ok);
    tick();
    branch_taken = 1'b1;
    branch_target = 32'h0000_0100;
    tick();
    branch_taken = 1'b0;
    clear_log();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL br_flush_valid got %b want 0", inst_valid); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL br_wait_req got %b want 0", bus.imem_req); end
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL br_req_timeout got 0 want 1"); end
    checks++; if (bus.imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL br_addr got %h want 00000100", bus.imem_addr); end
    repeat (16) tick();
    checks++; if (acc_pc_q.size() == 0 || acc_pc_q[0] !== 32'h100) begin errors++; $display("FAIL br_first_pc got %h want 00000100", acc_pc_q.size() ? acc_pc_q[0] : 32'hx); end
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL br_proto got %0d want 0", proto_viol); end

    // Redirect in the same cycle the response arrives.
    lat_fixed = 2;
    apply_reset();
    wait_req(ok);
    tick();
    tick();
    branch_taken = 1'b1;
    branch_target = 32'h0000_0200;
    tick();
    branch_taken = 1'b0;
    clear_log();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL br2_flush_valid got %b want 0", inst_valid); end
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL br2_req got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0000_0200) begin errors++; $display("FAIL br2_addr got %h want 00000200", bus.imem_addr); end
    repeat (16) tick();
    checks++; if (acc_pc_q.size() == 0 || acc_pc_q[0] !== 32'h200) begin errors++; $display("FAIL br2_first_pc got %h want 00000200", acc_pc_q.size() ? acc_pc_q[0] : 32'hx); end
  endtask

  task automatic test_wrap_align();
    lat_mode = 0;
    lat_fixed = 1;
    apply_reset();
    repeat (3) tick();
    branch_taken = 1'b1;
    branch_target = 32'h0000_0103;
    tick();
    branch_taken = 1'b0;
    clear_log();
    repeat (12) tick();
    checks++; if (acc_pc_q.size() < 2) begin errors++; $display("FAIL align_count got %0d want >=2", acc_pc_q.size()); end
    else begin
      checks++; if (acc_pc_q[0] !== 32'h100) begin errors++; $display("FAIL align_pc0 got %h want 00000100", acc_pc_q[0]); end
      checks++; if (acc_pc_q[1] !== 32'h104) begin errors++; $display("FAIL align_pc1 got %h want 00000104", acc_pc_q[1]); end
      checks++; if (acc_ins_q[0] !== mem_word(32'h100)) begin errors++; $display("FAIL align_instr got %h want %h", acc_ins_q[0], mem_word(32'h100)); end
    end
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    clear_log();
    repeat (12) tick();
    checks++; if (acc_pc_q.size() < 2) begin errors++; $display("FAIL wrap_count got %0d want >=2", acc_pc_q.size()); end
    else begin
      checks++; if (acc_pc_q[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got %h want fffffffc", acc_pc_q[0]); end
      checks++; if (acc_pc_q[1] !== 32'h0) begin errors++; $display("FAIL wrap_pc1 got %h want 00000000", acc_pc_q[1]); end
    end
  endtask

  task automatic test_random_traffic();
    lat_mode = 2;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 99) < 30);
      branch_taken = ($urandom_range(0, 99) < 4);
      branch_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      tick();
    end
    stall = 1'b0;
    branch_taken = 1'b0;
    repeat (20) tick();
    checks++; if (acc_pc_q.size() < 10) begin errors++; $display("FAIL rand_count got %0d want >=10", acc_pc_q.size()); end
    for (int i = 0; i < acc_pc_q.size(); i++) begin
      checks++; if (acc_pc_q[i] !== exp_pc_q[i]) begin errors++; $display("FAIL rand_pc[%0d] got %h want %h", i, acc_pc_q[i], exp_pc_q[i]); end
      checks++; if (acc_ins_q[i] !== mem_word(acc_pc_q[i])) begin errors++; $display("FAIL rand_instr[%0d] got %h want %h", i, acc_ins_q[i], mem_word(acc_pc_q[i])); end
    end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL rand_stall_hold got %0d want 0", hold_viol); end
    checks++; if (req_viol != 0) begin errors++; $display("FAIL rand_req_gating got %0d want 0", req_viol); end
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL rand_req_in_wait got %0d want 0", proto_viol); end
  endtask

  task automatic test_reset_midop();
    bit ok;
    lat_mode = 0;
    lat_fixed = 5;
    apply_reset();
    branch_taken = 1'b1;
    branch_target = 32'h0000_0040;
    tick();
    branch_taken = 1'b0;
    wait_req(ok);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", inst_valid); end
    checks++; if (pc_out !== RESET_PC) begin errors++; $display("FAIL mid_rst_pc got %h want %h", pc_out, RESET_PC); end
    checks++; if (instruction !== NOP) begin errors++; $display("FAIL mid_rst_instr got %h want %h", instruction, NOP); end
    tick();
    rst = 1'b0;
    clear_log();
    proto_viol = 0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL mid_rst_req got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL mid_rst_addr got %h want %h", bus.imem_addr, RESET_PC); end
    repeat (20) tick();
    checks++; if (acc_pc_q.size() == 0 || acc_pc_q[0] !== RESET_PC) begin errors++; $display("FAIL mid_rst_first_pc got %h want %h", acc_pc_q.size() ? acc_pc_q[0] : 32'hx, RESET_PC); end
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL mid_rst_proto got %0d want 0", proto_viol); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_variable_latency();
    test_stall_skid();
    test_branch_flush();
    test_wrap_align();
    test_random_traffic();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
